// File: rtl/fir_coeff_ctrl.sv
// Coefficient shadow/active bank controller that drains the FIR pipeline before swapping banks.
// Optional FIR_COEFF_READBACK_EN adds a registered shadow-bank read port (rd_addr/rd_data).
module fir_coeff_ctrl #(
  parameter int NUM_TAPS = 8,
  parameter int COEFF_W  = 32,
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NUM_TAPS)-1:0]   cfg_addr,
  input  logic [COEFF_W-1:0]            cfg_data,
  input  logic                          cfg_commit,
  output logic                          commit_done,
  output logic                          busy,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  output logic [DATA_W-1:0]             fir_x,
  output logic [NUM_TAPS*COEFF_W-1:0]   coeff_active,
  output logic                          y_valid,
  output logic [1:0]                    dbg_state
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [$clog2(NUM_TAPS)-1:0]   rd_addr,
  output logic [COEFF_W-1:0]            rd_data
`endif
);

  localparam int AW = $clog2(NUM_TAPS);
  localparam int VL = 1 + PIPE_LAT;
  localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]   NT   = (AW + 1)'(NUM_TAPS);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       drain_cnt_q;
  logic [AW-1:0]       fill_cnt_q;
  logic [VL-1:0]       vld_sr_q;
  logic [COEFF_W-1:0]  shadow_q [NUM_TAPS];
  logic [COEFF_W-1:0]  active_q [NUM_TAPS];
  logic                primed;
  logic                cfg_wr;
  logic                s_take;
  logic                vld_in;

  // Handshakes: a write or sample transfers on a cycle where valid and ready are both high;
  // ready depends only on FSM state, never on valid, and is high only in RUN.
  assign primed = (fill_cnt_q == LAST);
  assign cfg_wr = cfg_valid && cfg_ready && ({1'b0, cfg_addr} < NT);
  assign s_take = s_valid && s_ready;
  assign vld_in = s_take && primed;

  assign dbg_state = state_q;
  assign y_valid   = vld_sr_q[VL-1];

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    case (state_q)
      RUN: begin
        cfg_ready = 1'b1;
        s_ready   = 1'b1;
        if (cfg_commit) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_q == LAST) state_d = SWAP;
      end
      SWAP: begin
        busy    = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      fill_cnt_q  <= '0;
      vld_sr_q    <= '0;
      fir_x       <= '0;
      commit_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      commit_done <= (state_q == SWAP);
      // The filter advances every clock, so idle and drain cycles push zeros.
      fir_x       <= s_take ? s_data : '0;
      if (state_q == DRAIN && drain_cnt_q != LAST)
        drain_cnt_q <= drain_cnt_q + AW'(1);
      else
        drain_cnt_q <= '0;
      if (state_q == SWAP) begin
        fill_cnt_q <= '0;
        vld_sr_q   <= '0;
      end else begin
        if (state_q == RUN && !primed) fill_cnt_q <= fill_cnt_q + AW'(1);
        vld_sr_q <= (vld_sr_q << 1) | VL'(vld_in);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= COEFF_W'(k == 0);
        active_q[k] <= COEFF_W'(k == 0);
      end
    end else begin
      if (cfg_wr) shadow_q[cfg_addr] <= cfg_data;
      // Shadow keeps its contents after the swap so the host can edit incrementally.
      if (state_q == SWAP) begin
        for (int k = 0; k < NUM_TAPS; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_flat
    assign coeff_active[k*COEFF_W +: COEFF_W] = active_q[k];
  end

`ifdef FIR_COEFF_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= ({1'b0, rd_addr} < NT) ? shadow_q[rd_addr] : '0;
  end
`endif

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
Configuration and sequencing controller placed in front of FIR_filter. It holds a shadow and an active coefficient bank. Host writes go into the shadow bank; on commit, the controller drains the filter pipeline with zeros, then swaps the shadow bank into the active bank. It also registers the sample stream into the filter and produces a valid flag aligned to filter output y.

Parameters:
NUM_TAPS, 8, number of FIR taps (≥2)
COEFF_W, 32, coefficient width in bits
DATA_W, 32, sample width in bits
PIPE_LAT, 1, FIR_filter latency from x to y in clocks (≥0)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  coefficient write request
cfg_ready  out  1  controller can accept a write
cfg_addr  in  $clog2(NUM_TAPS)  tap index
cfg_data  in  COEFF_W  coefficient value
cfg_commit  in  1  single-cycle pulse: apply shadow bank
commit_done  out  1  single-cycle pulse when swap completes
busy  out  1  drain or swap in progress
s_valid  in  1  input sample valid
s_ready  out  1  controller accepts a sample
s_data  in  DATA_W  input sample
fir_x  out  DATA_W  registered sample to FIR_filter.incoming_signal_x
coeff_active  out  NUM_TAPS*COEFF_W  active bank; tap k at bits [k*COEFF_W +: COEFF_W]
y_valid  out  1  FIR_filter.output_signal_y is valid this cycle

Behaviour:
- FSM states: RUN, DRAIN, SWAP. Reset state is RUN.
- Reset values: fir_x=0; y_valid=0; commit_done=0; busy=0. Both banks reset to identity: tap0=1, all other taps=0. The drain counter and fill counter reset to 0.
- RUN:
  - cfg_ready=1 and s_ready=1.
  - When cfg_valid=1, shadow[cfg_addr] is written with cfg_data on the next edge.
  - fir_x is updated every clock: s_data if s_valid, else 0 (zero-stuff, because the filter advances every clock).
- RUN→DRAIN on cfg_commit=1.
  - If cfg_valid and cfg_commit are both high in the same cycle, the write lands first and is included in the commit.
- DRAIN:
  - cfg_ready=0, s_ready=0, busy=1, fir_x=0.
  - Lasts exactly NUM_TAPS cycles, counted by the drain counter 0..NUM_TAPS-1, then goes to SWAP.
- SWAP (1 cycle):
  - busy=1; active bank ← shadow bank.
  - commit_done=1 in the cycle after SWAP, coincident with the return to RUN.
  - The fill counter clears.
- cfg_commit outside RUN is ignored (no queueing).
- Out-of-range cfg_addr (≥NUM_TAPS, non-power-of-2 NUM_TAPS) is ignored; shadow is unchanged.
- Fill tracking: the fill counter increments per RUN cycle and saturates at NUM_TAPS-1. It sets a "primed" flag when full.
- y_valid is the "RUN-cycle and primed and s_valid accepted" bit delayed by 1+PIPE_LAT clocks through a shift register.
  - Zero-stuffed cycles give y_valid=0.
  - The shift register clears on reset and on SWAP.
- Reset asserted mid-DRAIN or SWAP: the FSM returns to RUN and both banks return to identity. No commit_done is issued.
- The shadow bank is unaffected by a commit; it keeps its contents for incremental edits.

Optional Feature:
FIR_COEFF_READBACK_EN
- Defined: adds ports rd_addr (in, $clog2(NUM_TAPS)) and rd_data (out, COEFF_W).
  - rd_data is registered: the shadow value at rd_addr, 1-cycle latency.
  - rd_data resets to 0. Out-of-range rd_addr reads 0.
- Undefined: the ports and the read logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then drive s_data=5,7,9 continuously → fir_x=5,7,9 one cycle later; coeff_active = {0,…,0,1}; y_valid rises after NUM_TAPS-1 fill cycles plus 1+PIPE_LAT.
2. Write taps 0..7 = 1..8 with cfg_valid, then pulse cfg_commit → busy high for 9 cycles (8 DRAIN + 1 SWAP); s_ready=0 and fir_x=0 throughout; commit_done pulses once; coeff_active tap3=4.
3. cfg_valid (addr 2, data 0x55) and cfg_commit in the same cycle → after commit, coeff_active tap2=0x55.
4. cfg_commit asserted during DRAIN, and cfg_valid during DRAIN → both ignored; exactly one commit_done; shadow unchanged by the DRAIN write.
5. Assert reset in DRAIN cycle 3 → next cycle: RUN, busy=0, no commit_done, coeff_active=identity, y_valid=0.
6. s_valid toggling 1,0,1 after primed → y_valid pattern 1,0,1 delayed 1+PIPE_LAT; with FIR_COEFF_READBACK_EN, rd_addr=2 after test 3 → rd_data=0x55 next cycle.
